// File: rtl/alu_writeback_pkg.sv
// Shared ALU control codes and writeback bundle layout for the alu32 writeback stage.
`ifndef ALU_WB_BUNDLE_W
`define ALU_WB_BUNDLE_W 37
`endif

package alu_writeback_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd2,
    ALU_SUB = 3'd3,
    ALU_AND = 3'd4,
    ALU_OR  = 3'd5,
    ALU_NOR = 3'd6,
    ALU_XOR = 3'd7
  } alu_ctrl_e;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned BUNDLE_W = `ALU_WB_BUNDLE_W;

  // One stored writeback entry: destination register and value (ADDR_W + DATA_W bits).
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Only add/subtract results carry a meaningful overflow indication.
  function automatic logic ctrl_has_overflow(input logic [2:0] ctrl);
    return (ctrl == ALU_ADD) || (ctrl == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_writeback_wb_fifo.sv
// Small synchronous FIFO holding pending register-file writes.
module wb_fifo
  import alu_writeback_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = BUNDLE_W
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head_data
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full      = (r_count == CNT_W'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign w_do_push   = i_push && !o_full;
  assign w_do_pop    = i_pop && !o_empty;
  assign o_head_data = o_empty ? '0 : r_mem[r_rd_ptr];

  // Storage array; contents are don't-care until the matching count makes them visible.
  always_ff @(posedge i_clock) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= PTR_W'(r_wr_ptr + 1'b1);
      if (w_do_pop)  r_rd_ptr <= PTR_W'(r_rd_ptr + 1'b1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= CNT_W'(r_count + 1'b1);
        2'b01:   r_count <= CNT_W'(r_count - 1'b1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/alu_writeback.sv
// Writeback stage after alu32: buffers results for the register-file port and tracks flags.
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_overflow,
  input  logic             in_zero,
  input  logic             in_negative,
  input  logic [2:0]       in_control,
  input  logic [4:0]       in_dest,
  output logic             wr_valid,
  input  logic             wr_ready,
  output logic [4:0]       wr_addr,
  output logic [31:0]      wr_data,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_v,
  output logic             sticky_v,
  output logic [CNT_W-1:0] ov_count,
  input  logic             clear_sticky
);

  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_arith;
  logic             w_ov_event;
  wb_entry_t        w_push_entry;
  wb_entry_t        w_head;

  logic             r_flag_n;
  logic             r_flag_z;
  logic             r_flag_v;
  logic             r_sticky_v;
  logic [CNT_W-1:0] r_ov_count;

  // in_ready depends only on occupancy and reset, never on wr_ready.
  assign in_ready     = reset && !w_fifo_full;
  assign w_accept     = in_valid && in_ready;
  assign w_push       = w_accept && (in_dest != '0);
  assign wr_valid     = !w_fifo_empty;
  assign w_pop        = wr_valid && wr_ready;
  assign w_arith      = ctrl_has_overflow(in_control);
  assign w_ov_event   = w_accept && w_arith && in_overflow;
  assign w_push_entry = '{addr: in_dest, data: in_data};
  assign wr_addr      = w_head.addr;
  assign wr_data      = w_head.data;

  assign flag_n   = r_flag_n;
  assign flag_z   = r_flag_z;
  assign flag_v   = r_flag_v;
  assign sticky_v = r_sticky_v;
  assign ov_count = r_ov_count;

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (BUNDLE_W)
  ) u_fifo (
    .i_clock     (clock),
    .i_reset_n   (reset),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_head_data (w_head)
  );

  // Architectural N/Z/V follow every accepted bundle, including those aimed at register 0.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_flag_n <= 1'b0;
      r_flag_z <= 1'b0;
      r_flag_v <= 1'b0;
    end else if (w_accept) begin
      r_flag_n <= in_negative;
      r_flag_z <= in_zero;
      r_flag_v <= w_arith && in_overflow;
    end
  end

  // Sticky overflow and saturating counter; a same-cycle event outranks clear_sticky.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_sticky_v <= 1'b0;
      r_ov_count <= '0;
    end else begin
      if (w_ov_event)        r_sticky_v <= 1'b1;
      else if (clear_sticky) r_sticky_v <= 1'b0;

      if (clear_sticky) begin
        r_ov_count <= w_ov_event ? CNT_W'(1) : '0;
      end else if (w_ov_event && (r_ov_count != '1)) begin
        r_ov_count <= CNT_W'(r_ov_count + 1'b1);
      end
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed self-checking bench for alu_writeback.
module tb_alu_writeback;
  import alu_writeback_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_overflow;
  logic        in_zero;
  logic        in_negative;
  logic [2:0]  in_control;
  logic [4:0]  in_dest;
  logic        wr_valid;
  logic        wr_ready;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        flag_n;
  logic        flag_z;
  logic        flag_v;
  logic        sticky_v;
  logic [7:0]  ov_count;
  logic        clear_sticky;

  int checks   = 0;
  int failures = 0;

  alu_writeback #(
    .DEPTH (2),
    .CNT_W (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_overflow  (in_overflow),
    .in_zero      (in_zero),
    .in_negative  (in_negative),
    .in_control   (in_control),
    .in_dest      (in_dest),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .flag_n       (flag_n),
    .flag_z       (flag_z),
    .flag_v       (flag_v),
    .sticky_v     (sticky_v),
    .ov_count     (ov_count),
    .clear_sticky (clear_sticky)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] ctrl, input logic [31:0] d,
                       input logic [4:0] dst, input logic ov, input logic z, input logic n);
    in_valid    = v;
    in_control  = ctrl;
    in_data     = d;
    in_dest     = dst;
    in_overflow = ov;
    in_zero     = z;
    in_negative = n;
  endtask

  task automatic test_reset();
    reset = 1'b0; wr_ready = 1'b0; clear_sticky = 1'b0;
    drive(1'b0, 3'd0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL reset_wr_valid got=%b exp=0", wr_valid); end
    checks++; if ({wr_addr, wr_data} !== 37'h0) begin failures++; $display("FAIL reset_wr_bus got=%0h/%0h exp=0/0", wr_addr, wr_data); end
    checks++; if ({flag_n, flag_z, flag_v, sticky_v} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {flag_n, flag_z, flag_v, sticky_v}); end
    checks++; if (ov_count !== 8'd0) begin failures++; $display("FAIL reset_ov_count got=%0d exp=0", ov_count); end
    reset = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", in_ready); end
    tick();
  endtask

  task automatic test_single();
    wr_ready = 1'b1;
    drive(1'b1, ALU_ADD, 32'd12, 5'd3, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL single_no_comb got=%b exp=0", wr_valid); end
    tick();
    in_valid = 1'b0;
    checks++; if (wr_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", wr_valid); end
    checks++; if (wr_addr !== 5'd3) begin failures++; $display("FAIL single_addr got=%0d exp=3", wr_addr); end
    checks++; if (wr_data !== 32'd12) begin failures++; $display("FAIL single_data got=%0d exp=12", wr_data); end
    checks++; if ({flag_n, flag_z, flag_v} !== 3'b000) begin failures++; $display("FAIL single_flags got=%b exp=000", {flag_n, flag_z, flag_v}); end
    tick();
    checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL single_drained got=%b exp=0", wr_valid); end
  endtask

  task automatic test_backpressure();
    wr_ready = 1'b0;
    drive(1'b1, ALU_OR, 32'h100, 5'd5, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, ALU_OR, 32'h200, 5'd6, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, ALU_OR, 32'h300, 5'd7, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready got=%b exp=0", in_ready); end
    tick();
    checks++; if (wr_addr !== 5'd5 || wr_data !== 32'h100) begin failures++; $display("FAIL bp_stall_stable got=%0d/%0h exp=5/100", wr_addr, wr_data); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_still_full got=%b exp=0", in_ready); end
    wr_ready = 1'b1;
    tick();
    checks++; if (wr_valid !== 1'b1 || wr_addr !== 5'd6 || wr_data !== 32'h200) begin failures++; $display("FAIL bp_second got=%b/%0d/%0h exp=1/6/200", wr_valid, wr_addr, wr_data); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after_pop got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (wr_valid !== 1'b1 || wr_addr !== 5'd7 || wr_data !== 32'h300) begin failures++; $display("FAIL bp_third got=%b/%0d/%0h exp=1/7/300", wr_valid, wr_addr, wr_data); end
    tick();
    checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%b exp=0", wr_valid); end
  endtask

  task automatic test_dest0_and_flags();
    wr_ready = 1'b1;
    drive(1'b1, ALU_SUB, 32'hFFFF_FFFD, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL dest0_no_write got=%b exp=0", wr_valid); end
    checks++; if ({flag_n, flag_z, flag_v} !== 3'b100) begin failures++; $display("FAIL dest0_flags got=%b exp=100", {flag_n, flag_z, flag_v}); end
    drive(1'b1, ALU_AND, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0);
    tick();
    checks++; if ({flag_n, flag_z, flag_v} !== 3'b010) begin failures++; $display("FAIL and_ov_flags got=%b exp=010", {flag_n, flag_z, flag_v}); end
    checks++; if (sticky_v !== 1'b0 || ov_count !== 8'd0) begin failures++; $display("FAIL and_ov_sticky got=%b/%0d exp=0/0", sticky_v, ov_count); end
    checks++; if (wr_valid !== 1'b1 || wr_addr !== 5'd4) begin failures++; $display("FAIL and_write got=%b/%0d exp=1/4", wr_valid, wr_addr); end
    drive(1'b1, 3'd1, 32'h55, 5'd9, 1'b1, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    checks++; if (wr_valid !== 1'b1 || wr_addr !== 5'd9 || wr_data !== 32'h55) begin failures++; $display("FAIL undef_write got=%b/%0d/%0h exp=1/9/55", wr_valid, wr_addr, wr_data); end
    checks++; if ({flag_n, flag_z, flag_v} !== 3'b100 || ov_count !== 8'd0) begin failures++; $display("FAIL undef_flags got=%b/%0d exp=100/0", {flag_n, flag_z, flag_v}, ov_count); end
    tick();
  endtask

  task automatic test_saturation();
    wr_ready = 1'b1;
    drive(1'b1, ALU_ADD, 32'h8000_0000, 5'd0, 1'b1, 1'b0, 1'b1);
    tick();
    checks++; if (flag_v !== 1'b1 || sticky_v !== 1'b1 || ov_count !== 8'd1) begin failures++; $display("FAIL sat_first got=%b/%b/%0d exp=1/1/1", flag_v, sticky_v, ov_count); end
    for (int i = 1; i < 255; i++) tick();
    checks++; if (ov_count !== 8'd255) begin failures++; $display("FAIL sat_255 got=%0d exp=255", ov_count); end
    tick();
    checks++; if (ov_count !== 8'd255 || sticky_v !== 1'b1) begin failures++; $display("FAIL sat_hold got=%0d/%b exp=255/1", ov_count, sticky_v); end
    clear_sticky = 1'b1;
    tick();
    checks++; if (sticky_v !== 1'b1 || ov_count !== 8'd1) begin failures++; $display("FAIL clear_with_event got=%b/%0d exp=1/1", sticky_v, ov_count); end
    in_valid = 1'b0;
    tick();
    clear_sticky = 1'b0;
    checks++; if (sticky_v !== 1'b0 || ov_count !== 8'd0) begin failures++; $display("FAIL clear_alone got=%b/%0d exp=0/0", sticky_v, ov_count); end
    checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL sat_no_writes got=%b exp=0", wr_valid); end
  endtask

  task automatic test_reset_mid();
    int writes;
    wr_ready = 1'b0;
    drive(1'b1, ALU_SUB, 32'hA, 5'd10, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, ALU_ADD, 32'hB, 5'd11, 1'b1, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    checks++; if (wr_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL mid_filled got=%b/%b exp=1/0", wr_valid, in_ready); end
    reset = 1'b0;
    tick();
    checks++; if (wr_valid !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL mid_reset_out got=%b/%b exp=0/0", wr_valid, in_ready); end
    checks++; if ({flag_n, flag_z, flag_v, sticky_v} !== 4'b0000 || ov_count !== 8'd0) begin failures++; $display("FAIL mid_reset_flags got=%b/%0d exp=0000/0", {flag_n, flag_z, flag_v, sticky_v}, ov_count); end
    reset = 1'b1;
    wr_ready = 1'b1;
    writes = 0;
    for (int i = 0; i < 5; i++) begin
      if (wr_valid === 1'b1) writes++;
      tick();
    end
    checks++; if (writes !== 0) begin failures++; $display("FAIL mid_discarded got=%0d exp=0", writes); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_empty_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_addr;
    wr_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, ALU_XOR, 32'hA000 + 32'(i), 5'((i % 31) + 1), 1'b0, 1'b0, 1'b0);
      tick();
      exp_addr = 5'((i % 31) + 1);
      checks++;
      if (wr_valid !== 1'b1 || wr_addr !== exp_addr || wr_data !== 32'hA000 + 32'(i) || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_%0d got=%b/%0d/%0h/%b exp=1/%0d/%0h/1", i, wr_valid, wr_addr, wr_data, in_ready, exp_addr, 32'hA000 + 32'(i));
      end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL b2b_drained got=%b exp=0", wr_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_dest0_and_flags();
    test_saturation();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
